// File: rtl/test_pattern_pkg.sv
// rtl/test_pattern_pkg.sv - pattern select codes and checker FSM states
package test_pattern_pkg;

   // Pattern select codes, shared with the test pattern generator
   localparam logic [1:0] PATTERN_ALL_ZERO  = 2'b00;
   localparam logic [1:0] PATTERN_ALL_ONE   = 2'b01;
   localparam logic [1:0] PATTERN_ALTERNATE = 2'b10;
   localparam logic [1:0] PATTERN_INCREMENT = 2'b11;

   // Run counters are sized for LOCK_CNT / LOSS_CNT up to 255
   localparam int RUN_W = 8;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

endpackage

// File: rtl/tp_popcount.sv
// rtl/tp_popcount.sv - combinational population count of a DATA_W-bit word
module tp_popcount #(
   parameter int DATA_W = 32,
   localparam int CNT_W = $clog2(DATA_W + 1)
) (
   input  logic [DATA_W-1:0] data,
   output logic [CNT_W-1:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < DATA_W; i++) begin
         count = count + CNT_W'(data[i]);
      end
   end

endmodule

// File: rtl/test_pattern_checker.sv
// rtl/test_pattern_checker.sv - pattern checker with lock FSM and saturating error/word counters
// Optional macro CHECKER_BIT_ERR_EN adds the bit_err_count output.
module test_pattern_checker
   import test_pattern_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int LOCK_CNT  = 4,
   parameter int LOSS_CNT  = 4,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           pattern_sel,
   input  logic [DATA_W-1:0]    data_in,
   input  logic                 data_valid,
   input  logic                 clear_cnt,
   output logic                 locked,
   output logic                 error_flag,
   output logic [ERR_CNT_W-1:0] error_count,
   output logic [31:0]          word_count
`ifdef CHECKER_BIT_ERR_EN
   ,
   output logic [31:0]          bit_err_count
`endif
);

   chk_state_t         state;
   logic [1:0]         sel_q;
   logic [DATA_W-1:0]  prev;
   logic [DATA_W-1:0]  expected;
   logic [RUN_W-1:0]   match_run;
   logic [RUN_W-1:0]   miss_run;
   logic               sel_change;
   logic               mismatch;
   logic               match_done;
   logic               miss_done;
   logic               count_en;

   always_comb begin
      expected = '0;
      case (sel_q)
         PATTERN_ALL_ZERO:  expected = '0;
         PATTERN_ALL_ONE:   expected = '1;
         PATTERN_ALTERNATE: expected = ~prev;
         default:           expected = prev + DATA_W'(1);
      endcase
   end

   // A select change wins over the word presented in the same cycle
   assign sel_change = (pattern_sel != sel_q);
   assign mismatch   = (data_in != expected);
   assign match_done = (match_run == RUN_W'(LOCK_CNT - 1));
   assign miss_done  = (miss_run == RUN_W'(LOSS_CNT - 1));
   assign count_en   = data_valid && !sel_change && (state == LOCKED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         sel_q      <= PATTERN_ALL_ZERO;
         prev       <= '0;
         match_run  <= '0;
         miss_run   <= '0;
         locked     <= 1'b0;
         error_flag <= 1'b0;
      end else begin
         error_flag <= 1'b0;
         if (sel_change) begin
            sel_q     <= pattern_sel;
            state     <= HUNT;
            match_run <= '0;
            miss_run  <= '0;
            locked    <= 1'b0;
         end else if (data_valid) begin
            case (state)
               HUNT: begin
                  prev      <= data_in;
                  match_run <= '0;
                  state     <= SYNC;
               end
               SYNC: begin
                  prev <= data_in;
                  if (mismatch) begin
                     match_run <= '0;
                  end else if (match_done) begin
                     match_run <= '0;
                     miss_run  <= '0;
                     state     <= LOCKED;
                     locked    <= 1'b1;
                  end else begin
                     match_run <= match_run + RUN_W'(1);
                  end
               end
               LOCKED: begin
                  // Flywheel on the expected word so a single corrupt word costs one error
                  prev <= expected;
                  if (mismatch) begin
                     error_flag <= 1'b1;
                     if (miss_done) begin
                        miss_run  <= '0;
                        match_run <= '0;
                        state     <= HUNT;
                        locked    <= 1'b0;
                     end else begin
                        miss_run <= miss_run + RUN_W'(1);
                     end
                  end else begin
                     miss_run <= '0;
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error_count <= '0;
         word_count  <= '0;
      end else if (clear_cnt) begin
         error_count <= '0;
         word_count  <= '0;
      end else if (count_en) begin
         if (word_count != '1) begin
            word_count <= word_count + 32'd1;
         end
         if (mismatch && (error_count != '1)) begin
            error_count <= error_count + ERR_CNT_W'(1);
         end
      end
   end

`ifdef CHECKER_BIT_ERR_EN
   localparam int POP_W = $clog2(DATA_W + 1);

   logic [POP_W-1:0] bit_errs;
   logic [32:0]      bit_sum;

   tp_popcount #(
      .DATA_W (DATA_W)
   ) u_popcount (
      .data  (data_in ^ expected),
      .count (bit_errs)
   );

   assign bit_sum = {1'b0, bit_err_count} + 33'(bit_errs);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_err_count <= '0;
      end else if (clear_cnt) begin
         bit_err_count <= '0;
      end else if (count_en) begin
         bit_err_count <= bit_sum[32] ? '1 : bit_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_test_pattern_checker.sv
// tb/tb_test_pattern_checker.sv - self-checking bench for test_pattern_checker
module tb_test_pattern_checker;

   localparam int LOCK_N  = 4;
   localparam int LOSS_N  = 4;
   localparam int ERR_W   = 8;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       pattern_sel;
   logic [31:0]      data_in;
   logic             data_valid;
   logic             clear_cnt;
   logic             locked;
   logic             error_flag;
   logic [ERR_W-1:0] error_count;
   logic [31:0]      word_count;
`ifdef CHECKER_BIT_ERR_EN
   logic [31:0]      bit_err_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // narrow error counter keeps saturation reachable in a short run
   test_pattern_checker #(
      .DATA_W    (32),
      .LOCK_CNT  (LOCK_N),
      .LOSS_CNT  (LOSS_N),
      .ERR_CNT_W (ERR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pattern_sel (pattern_sel),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .clear_cnt   (clear_cnt),
      .locked      (locked),
      .error_flag  (error_flag),
      .error_count (error_count),
      .word_count  (word_count)
`ifdef CHECKER_BIT_ERR_EN
      ,
      .bit_err_count (bit_err_count)
`endif
   );

   always #5 clk = ~clk;

   // reference model: 0 = hunting, 1 = syncing, 2 = locked
   int          m_state;
   logic [1:0]  m_sel;
   logic [31:0] m_prev;
   int          m_match;
   int          m_miss;
   logic        m_locked;
   logic        m_flag;
   longint      m_err;
   longint      m_words;
   longint      m_bits;

   function automatic logic [31:0] pat_next(input logic [1:0] s, input logic [31:0] p);
      case (s)
         2'd0:    return 32'h0;
         2'd1:    return 32'hFFFF_FFFF;
         2'd2:    return ~p;
         default: return p + 32'd1;
      endcase
   endfunction

   function automatic void model_reset();
      m_state = 0; m_sel = 2'd0; m_prev = '0; m_match = 0; m_miss = 0;
      m_locked = 1'b0; m_flag = 1'b0; m_err = 0; m_words = 0; m_bits = 0;
   endfunction

   function automatic void model_step(input logic [1:0] s, input logic v, input logic [31:0] d,
                                      input logic c);
      logic [31:0] e;
      e = pat_next(m_sel, m_prev);
      m_flag = 1'b0;
      if (s != m_sel) begin
         m_sel = s; m_state = 0; m_match = 0; m_miss = 0;
      end else if (v) begin
         if (m_state == 0) begin
            m_prev = d; m_match = 0; m_state = 1;
         end else if (m_state == 1) begin
            m_prev = d;
            if (d == e) begin
               m_match++;
               if (m_match == LOCK_N) begin m_state = 2; m_miss = 0; m_match = 0; end
            end else begin
               m_match = 0;
            end
         end else begin
            if (m_words < 64'hFFFF_FFFF) m_words++;
            m_bits = m_bits + $countones(d ^ e);
            if (m_bits > 64'hFFFF_FFFF) m_bits = 64'hFFFF_FFFF;
            m_prev = e;
            if (d != e) begin
               m_flag = 1'b1;
               if (m_err < ERR_MAX) m_err++;
               m_miss++;
               if (m_miss == LOSS_N) begin m_state = 0; m_miss = 0; m_match = 0; end
            end else begin
               m_miss = 0;
            end
         end
      end
      if (c) begin m_err = 0; m_words = 0; m_bits = 0; end
      m_locked = (m_state == 2);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic compare_model();
      check("model locked", 64'(locked), 64'(m_locked));
      check("model error_flag", 64'(error_flag), 64'(m_flag));
      check("model error_count", 64'(error_count), 64'(m_err));
      check("model word_count", 64'(word_count), 64'(m_words));
`ifdef CHECKER_BIT_ERR_EN
      check("model bit_err_count", 64'(bit_err_count), 64'(m_bits));
`endif
   endtask

   task automatic step(input logic [1:0] s, input logic v, input logic [31:0] d, input logic c);
      pattern_sel = s; data_valid = v; data_in = d; clear_cnt = c;
      @(posedge clk);
      #1;
      model_step(s, v, d, c);
      compare_model();
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic        valid;
      logic [31:0] data;
      logic        clr;
      logic        e_locked;
      logic        e_flag;
      int          e_err;
      int          e_words;
   } vec_t;

   vec_t tv[$];

   function automatic void add(input logic [1:0] s, input logic v, input logic [31:0] d,
                               input logic c, input logic el, input logic ef, input int ee,
                               input int ew);
      vec_t t;
      t.sel = s; t.valid = v; t.data = d; t.clr = c;
      t.e_locked = el; t.e_flag = ef; t.e_err = ee; t.e_words = ew;
      tv.push_back(t);
   endfunction

   initial begin
      logic [31:0] g_word;
      logic [1:0]  r_sel;
      logic [31:0] d;
      logic        v;
      logic        c;

      // increment lock: seed 0x10, lock after 0x14, 0x15..0x1F counted
      add(2'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
      add(2'd3, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 0, 0);
      for (int k = 1; k <= 3; k++) add(2'd3, 1'b1, 32'h10 + 32'(k), 1'b0, 1'b0, 1'b0, 0, 0);
      add(2'd3, 1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 0, 0);
      for (int k = 1; k <= 11; k++) add(2'd3, 1'b1, 32'h14 + 32'(k), 1'b0, 1'b1, 1'b0, 0, k);
      add(2'd3, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 0, 11);
      // single corrupted word with flywheel
      for (int k = 0; k < 4; k++) add(2'd3, 1'b1, 32'h20 + 32'(k), 1'b0, 1'b1, 1'b0, 0, 12 + k);
      add(2'd3, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1, 16);
      for (int k = 5; k < 8; k++) add(2'd3, 1'b1, 32'h20 + 32'(k), 1'b0, 1'b1, 1'b0, 1, 12 + k);
      add(2'd3, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0);

      rst_n = 1'b0; pattern_sel = 2'd0; data_in = '0; data_valid = 1'b0; clear_cnt = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset locked", 64'(locked), 64'd0);
      check("reset error_flag", 64'(error_flag), 64'd0);
      check("reset error_count", 64'(error_count), 64'd0);
      check("reset word_count", 64'(word_count), 64'd0);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         step(tv[i].sel, tv[i].valid, tv[i].data, tv[i].clr);
         check($sformatf("vec%0d locked", i), 64'(locked), 64'(tv[i].e_locked));
         check($sformatf("vec%0d error_flag", i), 64'(error_flag), 64'(tv[i].e_flag));
         check($sformatf("vec%0d error_count", i), 64'(error_count), 64'(tv[i].e_err));
         check($sformatf("vec%0d word_count", i), 64'(word_count), 64'(tv[i].e_words));
      end

      // loss of lock in alternate mode, then reseed and relock
      step(2'd2, 1'b0, 32'h0, 1'b0);
      check("alt sel change locked", 64'(locked), 64'd0);
      for (int k = 0; k < 5; k++) step(2'd2, 1'b1, k[0] ? 32'h5A5A_5A5A : 32'hA5A5_A5A5, 1'b0);
      check("alt locked", 64'(locked), 64'd1);
      step(2'd2, 1'b1, 32'h5A5A_5A5A, 1'b0);
      for (int k = 0; k < 4; k++) step(2'd2, 1'b1, 32'h0, 1'b0);
      check("loss error_count", 64'(error_count), 64'd4);
      check("loss locked", 64'(locked), 64'd0);
      step(2'd2, 1'b1, 32'h1234_5678, 1'b0);
      for (int k = 0; k < 4; k++) step(2'd2, 1'b1, k[0] ? 32'h1234_5678 : 32'hEDCB_A987, 1'b0);
      check("relock after reseed", 64'(locked), 64'd1);

      // increment wrap then mode change
      step(2'd3, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 9; k++) step(2'd3, 1'b1, 32'hFFFF_FFFA + 32'(k), 1'b0);
      check("wrap locked", 64'(locked), 64'd1);
      check("wrap error_count", 64'(error_count), 64'd4);
      step(2'd0, 1'b1, 32'h0, 1'b0);
      check("mode change unlock", 64'(locked), 64'd0);
      for (int k = 0; k < 4; k++) step(2'd0, 1'b1, 32'h0, 1'b0);
      check("zero not yet locked", 64'(locked), 64'd0);
      step(2'd0, 1'b1, 32'h0, 1'b0);
      check("zero relock", 64'(locked), 64'd1);

      // saturation and clear in all-ones mode
      step(2'd1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 5; k++) step(2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0);
      for (int k = 0; k < 84; k++) begin
         for (int j = 0; j < 3; j++) step(2'd1, 1'b1, 32'h0, 1'b0);
         step(2'd1, 1'b1, 32'hFFFF_FFFF, 1'b0);
      end
      check("sat error_count", 64'(error_count), 64'(ERR_MAX));
      step(2'd1, 1'b1, 32'h0, 1'b0);
      check("sat hold", 64'(error_count), 64'(ERR_MAX));
      check("sat still locked", 64'(locked), 64'd1);
      step(2'd1, 1'b1, 32'h0, 1'b1);
      check("clear wins error_count", 64'(error_count), 64'd0);
      check("clear wins word_count", 64'(word_count), 64'd0);
      check("clear error_flag", 64'(error_flag), 64'd1);

      // randomized traffic against the model
      r_sel = 2'd1;
      g_word = $urandom;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            r_sel = 2'($urandom_range(0, 3));
            g_word = $urandom;
         end
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 149) == 0);
         d = g_word;
         if (v) begin
            g_word = pat_next(r_sel, g_word);
            if ($urandom_range(0, 11) == 0) d = d ^ ($urandom | 32'd1);
         end
         step(r_sel, v, d, c);
      end

      // reset while locked with three errors
      step(2'd1, 1'b0, 32'h0, 1'b0);
      step(2'd3, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 5; k++) step(2'd3, 1'b1, 32'h100 + 32'(k), 1'b0);
      for (int k = 5; k < 11; k++) step(2'd3, 1'b1, k[0] ? 32'h0 : 32'h100 + 32'(k), 1'b0);
      check("pre-reset error_count", 64'(error_count), 64'd3);
      check("pre-reset locked", 64'(locked), 64'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async reset locked", 64'(locked), 64'd0);
      check("async reset error_flag", 64'(error_flag), 64'd0);
      check("async reset error_count", 64'(error_count), 64'd0);
      check("async reset word_count", 64'(word_count), 64'd0);
      #10;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) step(2'd0, 1'b1, 32'h0, 1'b0);
      check("post-reset relock", 64'(locked), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
